// File: rtl/huff_pkg.sv
// huff_pkg: shared types and constants for the Huffman bit packer
// Contents:
//   state_t        packer FSM states (IDLE: no table, RUN, FLUSH)
//   MAX_CODE_LEN_W width of a per-symbol code length
//   SYM_W          symbol value width
//   CODE_W         width of one right-aligned code table entry
//   nbits_w()      width needed to count 0..out_w valid bits
package huff_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam int MAX_CODE_LEN_W = 8;
    localparam int SYM_W = 8;
    localparam int CODE_W = 16;

    function automatic int nbits_w(input int out_w);
        return $clog2(out_w + 1);
    endfunction

endpackage

// File: rtl/huff_code_lookup.sv
// huff_code_lookup: registered Huffman code table with length derivation and symbol match
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   load          capture the table inputs below (accepted load only)
//   bits_packed   count of codes per length, length i in bits [8*i-1 -: 8]
//   val_packed    symbol value per canonical index k
//   code_packed   right-aligned code per canonical index k
//   sym           symbol to look up
//   hit           sym matches a valid entry
//   code          low len bits of the matching entry's code, upper bits zero
//   len           code length of the matching entry
module huff_code_lookup
    import huff_pkg::*;
#(
    parameter int SYMBOLS  = 4,
    parameter int MAX_BITS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [8*MAX_BITS-1:0]       bits_packed,
    input  logic [SYM_W*SYMBOLS-1:0]    val_packed,
    input  logic [CODE_W*SYMBOLS-1:0]   code_packed,
    input  logic [SYM_W-1:0]            sym,
    output logic                        hit,
    output logic [CODE_W-1:0]           code,
    output logic [MAX_CODE_LEN_W-1:0]   len
);

    logic [SYM_W-1:0]          val_q  [SYMBOLS];
    logic [CODE_W-1:0]         code_q [SYMBOLS];
    logic [MAX_CODE_LEN_W-1:0] len_q  [SYMBOLS];
    logic [SYMBOLS-1:0]        ok_q;

    logic [MAX_CODE_LEN_W-1:0] len_d  [SYMBOLS];
    logic [SYMBOLS-1:0]        ok_d;
    logic [15:0]               cum;

    // len[k] is the first length whose running code count passes k;
    // indices never reached by the histogram total stay invalid
    always_comb begin
        cum = '0;
        for (int k = 0; k < SYMBOLS; k++) begin
            len_d[k] = '0;
            ok_d[k]  = 1'b0;
            cum      = '0;
            for (int i = 1; i <= MAX_BITS; i++) begin
                cum = cum + 16'(bits_packed[8*i-1 -: 8]);
                if (!ok_d[k] && cum > 16'(k)) begin
                    len_d[k] = MAX_CODE_LEN_W'(i);
                    ok_d[k]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ok_q <= '0;
            for (int k = 0; k < SYMBOLS; k++) begin
                val_q[k]  <= '0;
                code_q[k] <= '0;
                len_q[k]  <= '0;
            end
        end else if (load) begin
            ok_q <= ok_d;
            for (int k = 0; k < SYMBOLS; k++) begin
                val_q[k]  <= val_packed[SYM_W*k +: SYM_W];
                code_q[k] <= code_packed[CODE_W*k +: CODE_W];
                len_q[k]  <= len_d[k];
            end
        end
    end

    // scan from the top so the lowest matching index is the one left standing
    always_comb begin
        hit  = 1'b0;
        code = '0;
        len  = '0;
        for (int k = SYMBOLS - 1; k >= 0; k--) begin
            if (ok_q[k] && val_q[k] == sym) begin
                hit  = 1'b1;
                len  = len_q[k];
                code = code_q[k] & ((CODE_W'(1) << len_q[k]) - CODE_W'(1));
            end
        end
    end

endmodule

// File: rtl/huff_bit_packer.sv
// huff_bit_packer: maps symbols through a loaded Huffman table and packs codes MSB-first into words
// Build option: define HUFF_PAD_ONES_EN to pad the final flush word with ones instead of zeros.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   load                     table load strobe (accepted in IDLE, or RUN when empty)
//   BITS_packed              count of codes per length, length i in bits [8*i-1 -: 8]
//   HUFFMANVAL_packed        symbol value per canonical index k
//   HUFFMAN_CODE_packed      right-aligned code per canonical index k
//   in_valid/in_ready        symbol handshake, sym_in the symbol
//   flush                    one-cycle request to emit the padded partial word
//   out_valid/out_ready      word handshake
//   out_data                 packed word, first code bit at MSB
//   out_nbits                valid bits in out_data
//   out_last                 final word of a flush
//   flush_done               one-cycle pulse after a flush completes
//   table_valid              a table is loaded
//   sym_err                  sticky unmatched-symbol flag, cleared by accepted load
module huff_bit_packer
    import huff_pkg::*;
#(
    parameter int SYMBOLS  = 4,
    parameter int MAX_BITS = 16,
    parameter int OUT_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [8*MAX_BITS-1:0]       BITS_packed,
    input  logic [SYM_W*SYMBOLS-1:0]    HUFFMANVAL_packed,
    input  logic [CODE_W*SYMBOLS-1:0]   HUFFMAN_CODE_packed,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SYM_W-1:0]            sym_in,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_W-1:0]            out_data,
    output logic [nbits_w(OUT_W)-1:0]   out_nbits,
    output logic                        out_last,
    output logic                        flush_done,
    output logic                        table_valid,
    output logic                        sym_err
);

    localparam int AW = OUT_W + MAX_BITS;
    localparam int FW = $clog2(AW + 1);
    localparam int NW = nbits_w(OUT_W);

    state_t                    state;
    logic [AW-1:0]             acc;
    logic [FW-1:0]             fill;

    logic                      hit;
    logic [CODE_W-1:0]         code;
    logic [MAX_CODE_LEN_W-1:0] len;

    logic                      accept;
    logic                      can_out;
    logic                      pop;
    logic                      pad_pop;
    logic                      load_ok;
    logic [AW-1:0]             app;
    logic [OUT_W-1:0]          top_word;
    logic [OUT_W-1:0]          pad_word;

    huff_code_lookup #(
        .SYMBOLS  (SYMBOLS),
        .MAX_BITS (MAX_BITS)
    ) u_lookup (
        .clk         (clk),
        .rst         (rst),
        .load        (load_ok),
        .bits_packed (BITS_packed),
        .val_packed  (HUFFMANVAL_packed),
        .code_packed (HUFFMAN_CODE_packed),
        .sym         (sym_in),
        .hit         (hit),
        .code        (code),
        .len         (len)
    );

    assign in_ready = (state == RUN) && (fill < FW'(OUT_W));
    assign accept   = in_valid && in_ready;
    assign can_out  = !out_valid || out_ready;
    // pop needs fill >= OUT_W while accept needs fill < OUT_W, so they never coincide
    assign pop      = (fill >= FW'(OUT_W)) && can_out;
    assign pad_pop  = (state == FLUSH) && (fill != '0) && (fill < FW'(OUT_W)) && can_out;
    assign load_ok  = load && (state == IDLE || (state == RUN && fill == '0 && !out_valid));

    // pending bits sit left-aligned; a new code lands directly under them
    // (fill + len <= AW - 1 whenever a symbol is accepted, so the shift is in range)
    assign app      = AW'(code) << (FW'(AW) - fill - FW'(len));
    assign top_word = acc[AW-1 -: OUT_W];

    // bits below fill are always zero, so zero padding needs no masking
`ifdef HUFF_PAD_ONES_EN
    assign pad_word = top_word | ({OUT_W{1'b1}} >> fill);
`else
    assign pad_word = top_word;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            acc         <= '0;
            fill        <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_nbits   <= '0;
            out_last    <= 1'b0;
            flush_done  <= 1'b0;
            table_valid <= 1'b0;
            sym_err     <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            if (out_ready)
                out_valid <= 1'b0;
            if (accept && hit) begin
                acc  <= acc | app;
                fill <= fill + FW'(len);
            end
            if (accept && !hit)
                sym_err <= 1'b1;
            if (pop) begin
                out_valid <= 1'b1;
                out_data  <= top_word;
                out_nbits <= NW'(OUT_W);
                // a full word that empties the accumulator during a flush is its last word
                out_last  <= (state == FLUSH) && (fill == FW'(OUT_W));
                acc       <= acc << OUT_W;
                fill      <= fill - FW'(OUT_W);
            end
            if (pad_pop) begin
                out_valid <= 1'b1;
                out_data  <= pad_word;
                out_nbits <= NW'(fill);
                out_last  <= 1'b1;
                acc       <= '0;
                fill      <= '0;
            end
            if (state == RUN && flush)
                state <= FLUSH;
            if (state == FLUSH && fill == '0 && can_out) begin
                state      <= RUN;
                flush_done <= 1'b1;
            end
            if (load_ok) begin
                state       <= RUN;
                table_valid <= 1'b1;
                sym_err     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_huff_bit_packer.sv
// tb_huff_bit_packer: randomized and directed checks of huff_bit_packer against a bit-queue model
module tb_huff_bit_packer;
    import huff_pkg::*;

    localparam int SYMBOLS  = 4;
    localparam int MAX_BITS = 8;
    localparam int OUT_W    = 8;
    localparam int NW       = nbits_w(OUT_W);
`ifdef HUFF_PAD_ONES_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, load = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, out_last, flush_done, table_valid, sym_err;
    logic [7:0] sym_in = 8'h00;
    logic [OUT_W-1:0] out_data;
    logic [NW-1:0] out_nbits;
    logic [8*MAX_BITS-1:0] bits_p;
    logic [8*SYMBOLS-1:0] val_p;
    logic [16*SYMBOLS-1:0] code_p;

    logic [7:0]  t_bits [1:MAX_BITS];
    logic [7:0]  t_val  [SYMBOLS];
    logic [15:0] t_code [SYMBOLS];
    logic [7:0]  m_bits [1:MAX_BITS];
    logic [7:0]  m_val  [SYMBOLS];
    logic [15:0] m_code [SYMBOLS];

    for (genvar g = 1; g <= MAX_BITS; g++) begin : g_b
        assign bits_p[8*g-1 -: 8] = t_bits[g];
    end
    for (genvar g = 0; g < SYMBOLS; g++) begin : g_s
        assign val_p[8*g +: 8]   = t_val[g];
        assign code_p[16*g +: 16] = t_code[g];
    end

    huff_bit_packer #(.SYMBOLS(SYMBOLS), .MAX_BITS(MAX_BITS), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .load(load), .BITS_packed(bits_p), .HUFFMANVAL_packed(val_p),
        .HUFFMAN_CODE_packed(code_p), .in_valid(in_valid), .in_ready(in_ready), .sym_in(sym_in),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_nbits(out_nbits), .out_last(out_last), .flush_done(flush_done),
        .table_valid(table_valid), .sym_err(sym_err)
    );

    always #5 clk = ~clk;

    bit rnd_rdy = 1'b0, rdy_force = 1'b1;
    always @(posedge clk) begin
        #2;
        out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_line(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // model: pending code bits in arrival order plus the sticky flags
    bit bq[$];
    bit serr_m = 0, tv_m = 0, fl_m = 0;
    bit pv = 0, pr = 0, pl = 0;
    logic [7:0] pd;
    logic [NW-1:0] pn;
    logic [7:0] lg_d[$];
    int lg_n[$];
    bit lg_l[$];

    function automatic void lk(input logic [7:0] s, output bit hit, output int len, output int code);
        int c, lk_len;
        hit = 0; len = 0; code = 0;
        for (int k = 0; k < SYMBOLS && !hit; k++) begin
            c = 0; lk_len = 0;
            for (int i = 1; i <= MAX_BITS; i++) begin
                c += int'(m_bits[i]);
                if (lk_len == 0 && c > k) lk_len = i;
            end
            if (lk_len != 0 && m_val[k] == s) begin
                hit = 1; len = lk_len; code = int'(m_code[k]) & ((1 << lk_len) - 1);
            end
        end
    endfunction

    always @(negedge clk) begin
        bit h;
        int l, cd, n;
        logic [7:0] w;
        if (!rst) begin
            bq.delete(); serr_m = 0; tv_m = 0; fl_m = 0; pv = 0;
        end else begin
            chk("table_valid", table_valid, tv_m);
            chk("sym_err", sym_err, serr_m);
            if (flush_done) begin
                chk("flush_done_expected", fl_m, 1);
                chk("flush_drained", bq.size(), 0);
                fl_m = 0;
            end
            if (pv && !pr) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, pd);
                chk("hold_nbits", out_nbits, pn);
                chk("hold_last", out_last, pl);
            end
            if (out_valid && out_ready) begin
                if (bq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_word: got %0h with no bits pending", out_data);
                end else begin
                    n = bq.size() < OUT_W ? bq.size() : OUT_W;
                    w = '0;
                    for (int i = 0; i < OUT_W; i++) w = {w[6:0], (i < n) ? bq[i] : PAD};
                    chk("word_data", out_data, w);
                    chk("word_nbits", out_nbits, n);
                    chk("word_last", out_last, fl_m && bq.size() <= OUT_W);
                    lg_d.push_back(out_data); lg_n.push_back(int'(out_nbits)); lg_l.push_back(out_last);
                    repeat (n) void'(bq.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                lk(sym_in, h, l, cd);
                if (h) for (int i = l - 1; i >= 0; i--) bq.push_back(cd[i]);
                else serr_m = 1;
            end
            if (flush && tv_m && !fl_m) fl_m = 1;
            if (load && (!tv_m || (bq.size() == 0 && !out_valid && !fl_m))) begin
                tv_m = 1; serr_m = 0;
                m_bits = t_bits; m_val = t_val; m_code = t_code;
            end
            pv = out_valid; pr = out_ready; pd = out_data; pn = out_nbits; pl = out_last;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] s, input bit with_flush);
        int t = 0;
        in_valid = 1; sym_in = s;
        while (!in_ready) begin
            if (t++ >= 200) begin fail_line("send"); break; end
            tick();
        end
        flush = with_flush;
        tick();
        in_valid = 0; flush = 0;
    endtask

    task automatic wait_fd;
        int t = 0;
        while (!flush_done && t < 300) begin tick(); t++; end
        if (t >= 300) fail_line("flush_done");
        else n_chk++;
        tick();
    endtask

    task automatic do_flush;
        int t = 0;
        while (!(in_ready && !out_valid) && t < 300) begin tick(); t++; end
        if (t >= 300) fail_line("flush_ready");
        flush = 1;
        tick();
        flush = 0;
        wait_fd();
    endtask

    task automatic do_load;
        int t = 0;
        while (out_valid && t < 300) begin tick(); t++; end
        if (t >= 300) fail_line("load_ready");
        load = 1;
        tick();
        load = 0;
    endtask

    task automatic set_table(input int id);
        for (int i = 1; i <= MAX_BITS; i++) t_bits[i] = 8'd0;
        if (id == 0) begin
            t_bits[1] = 1; t_bits[2] = 1; t_bits[3] = 2;
            t_val = '{8'h41, 8'h42, 8'h43, 8'h44};
            t_code = '{16'd0, 16'd2, 16'd6, 16'd7};
        end else if (id == 1) begin
            t_bits[2] = 4;
            t_val = '{8'h10, 8'h20, 8'h30, 8'h10};
            t_code = '{16'd0, 16'd1, 16'd2, 16'd3};
        end else begin
            t_bits[2] = 1; t_bits[3] = 1;
            t_val = '{8'h01, 8'h02, 8'h03, 8'h04};
            t_code = '{16'd1, 16'd5, 16'd0, 16'd0};
        end
    endtask

    task automatic clr_log;
        lg_d.delete(); lg_n.delete(); lg_l.delete();
    endtask

    task automatic basic(input string tag);
        clr_log();
        send(8'h41, 0); send(8'h42, 0); send(8'h43, 0); send(8'h44, 0);
        do_flush();
        chk({tag, "_count"}, lg_d.size(), 2);
        if (lg_d.size() == 2) begin
            chk({tag, "_w0"}, lg_d[0], 8'h5B);
            chk({tag, "_n0"}, lg_n[0], 8);
            chk({tag, "_l0"}, lg_l[0], 0);
            chk({tag, "_w1"}, lg_d[1], PAD ? 8'hFF : 8'h80);
            chk({tag, "_n1"}, lg_n[1], 1);
            chk({tag, "_l1"}, lg_l[1], 1);
        end
    endtask

    initial begin
        bit h;
        int l, cd, nsym;
        logic [7:0] s;
        set_table(0);
        #1 rst = 0;
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_nbits", out_nbits, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_table_valid", table_valid, 0);
        chk("rst_sym_err", sym_err, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1;
        tick();
        flush = 1; tick(); flush = 0;
        repeat (3) begin chk("idle_flush_ignored", flush_done, 0); tick(); end

        do_load();
        chk("in_ready_after_load", in_ready, 1);
        basic("basic");

        clr_log();
        send(8'h43, 0); send(8'h44, 0); send(8'h42, 1);
        wait_fd();
        chk("exact_count", lg_d.size(), 1);
        if (lg_d.size() == 1) begin
            chk("exact_w0", lg_d[0], 8'hDE);
            chk("exact_n0", lg_n[0], 8);
            chk("exact_l0", lg_l[0], 1);
        end

        clr_log();
        do_flush();
        chk("empty_flush_words", lg_d.size(), 0);

        clr_log();
        rdy_force = 0;
        tick();
        for (int r = 0; r < 2; r++) begin
            send(8'h41, 0); send(8'h42, 0); send(8'h43, 0); send(8'h44, 0);
        end
        repeat (5) tick();
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_data", out_data, 8'h5B);
        rdy_force = 1;
        do_flush();
        chk("bp_count", lg_d.size(), 3);
        if (lg_d.size() == 3) begin
            chk("bp_w1", lg_d[1], 8'hAD);
            chk("bp_w2", lg_d[2], PAD ? 8'hFF : 8'hC0);
            chk("bp_n2", lg_n[2], 2);
        end

        clr_log();
        send(8'h41, 0); send(8'h55, 0); send(8'h41, 0);
        chk("unmatched_sym_err", sym_err, 1);
        do_flush();
        chk("unmatched_count", lg_d.size(), 1);
        if (lg_d.size() == 1) begin
            chk("unmatched_w0", lg_d[0], PAD ? 8'h3F : 8'h00);
            chk("unmatched_n0", lg_n[0], 2);
        end
        chk("sym_err_sticky", sym_err, 1);
        do_load();
        chk("load_clears_sym_err", sym_err, 0);

        rnd_rdy = 1;
        for (int tb_id = 0; tb_id < 3; tb_id++) begin
            set_table(tb_id);
            do_load();
            for (int r = 0; r < 25; r++) begin
                nsym = $urandom_range(1, 12);
                for (int j = 0; j < nsym; j++) begin
                    s = ($urandom_range(0, 7) == 0) ? 8'($urandom) : t_val[$urandom_range(0, SYMBOLS - 1)];
                    lk(s, h, l, cd);
                    if (j == nsym - 1 && h && $urandom_range(0, 1) == 1) begin
                        send(s, 1);
                        wait_fd();
                    end else begin
                        send(s, 0);
                        if (j == nsym - 1) do_flush();
                    end
                    if ($urandom_range(0, 3) == 0) tick();
                end
            end
        end
        rnd_rdy = 0;

        set_table(0);
        do_load();
        send(8'h42, 0); send(8'h43, 0);
        #2 rst = 0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_nbits", out_nbits, 0);
        chk("arst_out_last", out_last, 0);
        chk("arst_table_valid", table_valid, 0);
        chk("arst_sym_err", sym_err, 0);
        chk("arst_in_ready", in_ready, 0);
        tick();
        rst = 1;
        tick();
        chk("post_rst_in_ready", in_ready, 0);
        do_load();
        basic("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/huff_bit_packer.md
# huff_bit_packer

Downstream stage of the canonical Huffman code generator. Latches the code table and the length histogram on a load strobe, derives per-symbol code lengths, then maps a symbol stream through the table and packs variable-length codes MSB-first into fixed-width output words. Valid/ready handshakes on both sides; a flush command emits the final padded partial word.

## Interface
- SYMBOLS, 4, table entries; must match the upstream generator
- MAX_BITS, 16, longest code length
- OUT_W, 32, output word width (≥ MAX_BITS)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- load  in  1  table load strobe; tie to upstream done
- BITS_packed  in  8*MAX_BITS  count of codes per length, length i in bits [8*i-1 -: 8]
- HUFFMANVAL_packed  in  8*SYMBOLS  symbol value per canonical index k
- HUFFMAN_CODE_packed  in  16*SYMBOLS  right-aligned code per canonical index k
- in_valid / in_ready  in / out  1 / 1  symbol handshake
- sym_in  in  8  symbol value
- flush  in  1  one-cycle flush request
- out_valid / out_ready  out / in  1 / 1  word handshake
- out_data  out  OUT_W  packed word, first code bit at MSB
- out_nbits  out  $clog2(OUT_W+1)  valid bits in out_data
- out_last  out  1  final word of a flush
- flush_done  out  1  one-cycle pulse, flush complete
- table_valid  out  1  a table is loaded
- sym_err  out  1  sticky: unmatched symbol seen; cleared by accepted load

## Operation
- States: IDLE (no table), RUN, FLUSH. Reset → IDLE.
- Load is accepted in IDLE, or in RUN when fill==0 and !out_valid. Otherwise it is ignored. On acceptance: tables registered; len[k] = smallest i in 1..MAX_BITS with cum(i) > k, where cum(i) = ΣBITS[1..i] (16-bit sum). Entries with k ≥ total are marked invalid. Also sets table_valid=1, clears sym_err, next state RUN.
- Lookup: sym_in is compared against all valid HUFFMANVAL entries; the lowest matching k wins. Code is the low len[k] bits of HUFFMAN_CODE[k].
- No match: symbol is consumed and dropped, sym_err set, fill unchanged.
- Accumulator is OUT_W+MAX_BITS bits wide. fill is the count of pending bits. An accepted code is appended directly below the existing bits, and fill += len.
- in_ready = (state==RUN) && fill < OUT_W. It does not depend on flush.
- Pop: when fill ≥ OUT_W and (!out_valid || out_ready), the top OUT_W bits are moved to out_data, out_nbits=OUT_W, the accumulator shifts left by OUT_W, and fill -= OUT_W. Pop and accept never coincide.
- flush in RUN → FLUSH. A symbol accepted in the same cycle as flush is included.
- In FLUSH, full words pop as in RUN. Then, if 0 < fill < OUT_W, one padded word is emitted with out_nbits=fill. The last word emitted in FLUSH carries out_last=1.
- If FLUSH has no bits to emit, no out_last is produced.
- FLUSH → RUN when fill==0 and (!out_valid || out_ready). flush_done pulses in the following cycle.
- flush in IDLE: ignored. flush while in FLUSH: ignored.

## Timing
- Reset values: out_valid=0, out_data=0, out_nbits=0, out_last=0, flush_done=0, table_valid=0, sym_err=0, fill=0, state=IDLE.
- Load accepted at edge N → in_ready can rise after edge N+1.
- A symbol accepted at edge N that brings fill to ≥ OUT_W → out_valid high after edge N+1, data valid in the same cycle.
- Throughput: one symbol per cycle, with one bubble cycle per emitted word.
- out_data, out_nbits and out_last are held stable while out_valid && !out_ready.
- Reset mid-packet discards all pending bits and the table.

## Configuration
- HUFF_PAD_ONES_EN defined: flush padding bits are 1 (JPEG-style).
- HUFF_PAD_ONES_EN undefined: flush padding bits are 0.
- Only padding changes. out_nbits is identical in both builds.

## Structure
- Package huff_pkg holds: the state enum (IDLE/RUN/FLUSH), MAX_CODE_LEN_W=8, SYM_W=8, CODE_W=16, and a function for the out_nbits width.
- Sub-module huff_code_lookup contains the registered value/code/length table, the length derivation, and the symbol match. It returns {hit, code, len}.
- The top level holds the FSM, accumulator and output register.

## Test plan
All scenarios use OUT_W=8, BITS[1..3]={1,1,2}, HUFFMANVAL={0x41,0x42,0x43,0x44}, codes {0,2,6,7}.
- Basic packing: load, stream 0x41,0x42,0x43,0x44, flush → word 0x5B with out_nbits=8, then 0x80 with out_nbits=1 and out_last=1, then flush_done pulse.
- Padding macro: same stimulus with HUFF_PAD_ONES_EN → second word is 0xFF, out_nbits=1.
- Backpressure: out_ready=0 for 5 cycles after the first word → out_data stays 0x5B, in_ready drops once fill ≥ 8, no bits lost.
- Unmatched symbol: send 0x55 → consumed, sym_err=1, fill unchanged; the next load clears sym_err.
- Exact-multiple flush: stream 0x43,0x44,0x42 (8 bits), flush → single word 0xDE with out_last=1, out_nbits=8.
- Async reset: assert rst low mid-stream with fill=5 → all outputs 0, table_valid=0, in_ready=0 immediately.
